mem_port_arbiter: RTL

- Shares one memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the PC/CTRL fetch path and the load/store path on one side, and the single memory port on the other.
- Grants one requester at a time, registers the granted request, holds it on the memory port until the port acknowledges, then returns the response to the granted requester only.
- D has priority over I, with a starvation bound that guarantees I progress.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch (I) and load/store (D); D wins, bounded by a starve counter.
// Latency: grant cycle N, memory request from N+1, response pulse one cycle after the memory acknowledge (minimum 3 cycles).
// Backpressure: requests are held until the response pulse; the port stays busy until the memory acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_data_valid_o,
    output logic [DATA_W-1:0] i_data_o,
    input  logic              d_req_valid_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_wen_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_data_valid_o,
    output logic [DATA_W-1:0] d_data_o,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_data_valid_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              spurious_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter must be able to hold STARVE_MAX itself (saturation value).
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    state_t        state;
    logic [SW-1:0] starve;
    logic          grant_d;
    logic          grant_i;

    // D wins unless I has already been passed over STARVE_MAX times in a row.
    always_comb begin
        grant_d = d_req_valid_i && (!i_req_valid_i || (starve < STARVE_TOP));
        grant_i = i_req_valid_i && !grant_d;
    end

    // Arbitration FSM; every output is a register so the memory port sees clean, glitch-free fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            starve          <= '0;
            i_data_valid_o  <= 1'b0;
            i_data_o        <= '0;
            d_data_valid_o  <= 1'b0;
            d_data_o        <= '0;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
            mem_wen_o       <= 1'b0;
            mem_wdata_o     <= '0;
            spurious_o      <= 1'b0;
        end else begin
            // An acknowledge with nothing outstanding is flagged and otherwise dropped.
            if (mem_data_valid_i && (state == IDLE || state == RESP)) begin
                spurious_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state           <= BUSY_D;
                        mem_req_valid_o <= 1'b1;
                        mem_addr_o      <= d_addr_i;
                        mem_wen_o       <= d_wen_i;
                        mem_wdata_o     <= d_wdata_i;
                        if (i_req_valid_i && (starve != STARVE_TOP)) begin
                            starve <= starve + 1'b1;
                        end
                    end else if (grant_i) begin
                        state           <= BUSY_I;
                        mem_req_valid_o <= 1'b1;
                        mem_addr_o      <= i_addr_i;
                        mem_wen_o       <= 1'b0;
                        mem_wdata_o     <= '0;
                        starve          <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_data_valid_i) begin
                        state           <= RESP;
                        mem_req_valid_o <= 1'b0;
                        mem_addr_o      <= '0;
                        mem_wen_o       <= 1'b0;
                        mem_wdata_o     <= '0;
                        i_data_valid_o  <= 1'b1;
                        i_data_o        <= mem_data_i;
                    end
                end
                BUSY_D: begin
                    if (mem_data_valid_i) begin
                        state           <= RESP;
                        mem_req_valid_o <= 1'b0;
                        mem_addr_o      <= '0;
                        mem_wen_o       <= 1'b0;
                        mem_wdata_o     <= '0;
                        d_data_valid_o  <= 1'b1;
                        // Writes return an acknowledge only; whatever the bus carries is discarded.
                        d_data_o        <= mem_wen_o ? '0 : mem_data_i;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    i_data_valid_o <= 1'b0;
                    i_data_o       <= '0;
                    d_data_valid_o <= 1'b0;
                    d_data_o       <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
